// File: rtl/core_pkg.sv
// Shared types and constants for the pipelined RV32I core.
package core_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/if_fetch_stage_queue.sv
// Two-entry {pc, instr} FIFO between instruction fetch and decode.
// Flush has priority over push; a push into a full queue is taken only alongside a pop.
module if_queue
   import core_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_flush,
   input  logic       i_push,
   input  if_entry_t  i_data,
   input  logic       i_pop,
   output logic [1:0] o_count,
   output if_entry_t  o_head
);

   if_entry_t  r_mem [2];
   logic       r_rd_ptr;
   logic       r_wr_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to a latency-1 imem and
// queues {pc, instr} for decode. Optional counters under IF_FETCH_STAGE_PERF_EN.
module if_fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_vld,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_instr,
`ifdef IF_FETCH_STAGE_PERF_EN
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_killed,
`endif
   input  logic        i_id_rdy
);

   logic [31:0] r_pc;
   logic [31:0] r_resp_pc;
   logic        r_inflight;
   logic        r_kill;

   logic [1:0]  w_count;
   if_entry_t   w_head;
   if_entry_t   w_resp_entry;
   logic        w_pop;
   logic        w_push;
   logic        w_req;
   logic [2:0]  w_credit;

   // Occupancy the queue will have after this cycle, counting the outstanding response.
   assign w_pop    = o_if_vld && i_id_rdy;
   assign w_credit = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
   assign w_req    = !i_rst && !i_redirect && (w_credit < 3'd2);
   assign w_push   = r_inflight && !r_kill;

   assign w_resp_entry.pc    = r_resp_pc;
   assign w_resp_entry.instr = i_imem_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= word_align(RESET_PC);
         r_resp_pc  <= 32'd0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else if (i_redirect) begin
         r_pc       <= word_align(i_redirect_pc);
         r_inflight <= 1'b0;
         r_kill     <= r_inflight;
      end else begin
         r_inflight <= w_req;
         r_kill     <= 1'b0;
         if (w_req) begin
            r_pc      <= r_pc + 32'd4;
            r_resp_pc <= r_pc;
         end
      end
   end

   if_queue u_queue (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect),
      .i_push  (w_push),
      .i_data  (w_resp_entry),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_head  (w_head)
   );

`ifdef IF_FETCH_STAGE_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_killed;

   // A response is lost either to a pending kill or to a flush landing on its arrival cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_fetched <= 32'd0;
         r_perf_killed  <= 32'd0;
      end else begin
         if (w_pop) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (r_inflight && (r_kill || i_redirect)) begin
            r_perf_killed <= r_perf_killed + 32'd1;
         end
      end
   end

   assign o_perf_fetched = r_perf_fetched;
   assign o_perf_killed  = r_perf_killed;
`endif

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_if_vld    = (w_count != 2'd0) && !i_redirect;
   assign o_if_pc     = w_head.pc;
   assign o_if_instr  = w_head.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: transaction-level model of the fetch
// and delivery streams plus directed and randomized scenarios.
module tb_if_fetch_stage;
   import core_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        redir;
   logic [31:0] redir_pc;
   logic        vld;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        rdy;
`ifdef IF_FETCH_STAGE_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_killed;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic        mon_en = 1'b0;
   logic [31:0] exp_req;
   logic [31:0] exp_pop;
   logic        prev_req = 1'b0;
   int          pop_cnt = 0;
   int          exp_killed = 0;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (req),
      .o_imem_addr   (addr),
      .i_imem_rdata  (rdata),
      .i_redirect    (redir),
      .i_redirect_pc (redir_pc),
      .o_if_vld      (vld),
      .o_if_pc       (pc),
      .o_if_instr    (instr),
`ifdef IF_FETCH_STAGE_PERF_EN
      .o_perf_fetched(perf_fetched),
      .o_perf_killed (perf_killed),
`endif
      .i_id_rdy      (rdy)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory, latency 1
   always @(posedge clk) begin
      rdata <= req ? (addr ^ XOR_K) : 32'hDEAD_BEEF;
   end

   // Stream model: requests and deliveries each walk sequential word addresses,
   // restarting at the redirect target or RESET_PC.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            exp_req    = RST_PC;
            exp_pop    = RST_PC;
            pop_cnt    = 0;
            exp_killed = 0;
            prev_req   = 1'b0;
         end else begin
            if (req) begin
               n_checks++;
               if (addr !== exp_req) begin
                  n_errors++;
                  $display("FAIL req_addr: got %h expected %h at %0t", addr, exp_req, $time);
               end
               exp_req = exp_req + 32'd4;
            end
            if (vld && rdy) begin
               n_checks++;
               if (pc !== exp_pop || instr !== (exp_pop ^ XOR_K)) begin
                  n_errors++;
                  $display("FAIL deliver: got pc %h instr %h expected pc %h instr %h at %0t",
                           pc, instr, exp_pop, exp_pop ^ XOR_K, $time);
               end
               exp_pop = exp_pop + 32'd4;
               pop_cnt++;
            end
            if (redir) begin
               exp_req = redir_pc & ~32'd3;
               exp_pop = redir_pc & ~32'd3;
               if (prev_req) exp_killed++;
            end
            prev_req = req;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redir = 1'b0; redir_pc = 32'd0; rdy = 1'b1;
      mon_en = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_checks++;
      if (req !== 1'b0 || vld !== 1'b0 || addr !== RST_PC || pc !== 32'd0 || instr !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_state: req %b vld %b addr %h pc %h instr %h expected 0 0 %h 0 0",
                  req, vld, addr, pc, instr, RST_PC);
      end
`ifdef IF_FETCH_STAGE_PERF_EN
      n_checks++;
      if (perf_fetched !== 32'd0 || perf_killed !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_perf: fetched %0d killed %0d expected 0 0", perf_fetched, perf_killed);
      end
`endif
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b1 || addr !== RST_PC) begin
         n_errors++;
         $display("FAIL first_req: req %b addr %h expected 1 %h", req, addr, RST_PC);
      end
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if (vld !== 1'b1 || pc !== RST_PC) begin
         n_errors++;
         $display("FAIL first_vld: vld %b pc %h expected 1 %h", vld, pc, RST_PC);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if (vld !== 1'b1 || req !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_rate: vld %b req %b expected 1 1 (cycle %0d)", vld, req, i);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] head;
      tick();
      rdy = 1'b0;
      head = exp_pop;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 5) begin
            n_checks++;
            if (req !== 1'b0 || vld !== 1'b1 || pc !== head) begin
               n_errors++;
               $display("FAIL stall_hold: req %b vld %b pc %h expected 0 1 %h", req, vld, pc, head);
            end
         end
         tick();
      end
`ifdef IF_FETCH_STAGE_PERF_EN
      @(negedge clk);
      n_checks++;
      if (perf_fetched !== 32'(pop_cnt)) begin
         n_errors++;
         $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched, pop_cnt);
      end
      tick();
`endif
      rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (vld !== 1'b1) begin
            n_errors++;
            $display("FAIL no_bubble: vld %b expected 1 (cycle %0d after release)", vld, i);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      int budget;
      rdy = 1'b0;
      repeat (4) tick();
      rdy = 1'b1;
      tick();
      rdy = 1'b0; redir = 1'b1; redir_pc = 32'h0000_0102;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b0 || vld !== 1'b0) begin
         n_errors++;
         $display("FAIL redirect_cycle: req %b vld %b expected 0 0", req, vld);
      end
      tick();
      redir = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b1 || addr !== 32'h0000_0100) begin
         n_errors++;
         $display("FAIL redirect_req: req %b addr %h expected 1 00000100", req, addr);
      end
      budget = 0;
      while (vld !== 1'b1 && budget < 6) begin
         tick();
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (vld !== 1'b1 || pc !== 32'h0000_0100) begin
         n_errors++;
         $display("FAIL redirect_head: vld %b pc %h expected 1 00000100", vld, pc);
      end
`ifdef IF_FETCH_STAGE_PERF_EN
      n_checks++;
      if (perf_killed !== 32'(exp_killed) || exp_killed < 1) begin
         n_errors++;
         $display("FAIL perf_killed: got %0d expected %0d", perf_killed, exp_killed);
      end
`endif
      tick();
      rdy = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_redirect_handshake();
      int pops_before;
      rdy = 1'b1;
      repeat (3) tick();
      redir = 1'b1; redir_pc = 32'h0000_0200;
      @(negedge clk);
      pops_before = pop_cnt;
      n_checks++;
      if (vld !== 1'b0) begin
         n_errors++;
         $display("FAIL redirect_void: vld %b expected 0", vld);
      end
      tick();
      redir = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      n_checks++;
      if (pop_cnt - pops_before < 3) begin
         n_errors++;
         $display("FAIL redirect_resume: got %0d pops expected at least 3", pop_cnt - pops_before);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      int          seen;
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
      rdy = 1'b1;
      tick();
      redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
      tick();
      redir = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && seen < 3; i++) begin
         @(negedge clk);
         if (req) begin
            n_checks++;
            if (addr !== want[seen]) begin
               n_errors++;
               $display("FAIL wrap_addr: got %h expected %h", addr, want[seen]);
            end
            seen++;
         end
         tick();
      end
      n_checks++;
      if (seen != 3) begin
         n_errors++;
         $display("FAIL wrap_count: got %0d requests expected 3", seen);
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_midstream();
      rdy = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_req: req %b expected 0", req);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (vld !== 1'b0 || addr !== RST_PC || req !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_mid: vld %b addr %h req %b expected 0 %h 1", vld, addr, req, RST_PC);
      end
`ifdef IF_FETCH_STAGE_PERF_EN
      n_checks++;
      if (perf_fetched !== 32'd0 || perf_killed !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_mid_perf: fetched %0d killed %0d expected 0 0", perf_fetched, perf_killed);
      end
`endif
      tick();
      rdy = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_random();
      int pops_before;
      pops_before = pop_cnt;
      for (int i = 0; i < 400; i++) begin
         rdy      = ($urandom_range(0, 3) != 0);
         redir    = ($urandom_range(0, 19) == 0);
         redir_pc = $urandom;
         tick();
      end
      redir = 1'b0;
      rdy   = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      n_checks++;
      if (pop_cnt - pops_before < 100) begin
         n_errors++;
         $display("FAIL random_progress: got %0d pops expected at least 100", pop_cnt - pops_before);
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_redirect_handshake();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
